// File: rtl/ice51_mem_arb_if.sv
// Bus bundle for ice51_mem_arb: two requester ports plus the single memory port.
// The slave modport is the arbiter; the master modport is the surrounding system.
interface ice51_mem_arb_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  logic          i_r0_req;
  logic          i_r0_we;
  logic          i_r0_lock;
  logic [AW-1:0] i_r0_addr;
  logic [DW-1:0] i_r0_wdata;
  logic          o_r0_gnt;
  logic          o_r0_rvalid;
  logic [DW-1:0] o_r0_rdata;

  logic          i_r1_req;
  logic          i_r1_we;
  logic          i_r1_lock;
  logic [AW-1:0] i_r1_addr;
  logic [DW-1:0] i_r1_wdata;
  logic          o_r1_gnt;
  logic          o_r1_rvalid;
  logic [DW-1:0] o_r1_rdata;

  logic          o_mem_we;
  logic          o_mem_re;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;

  logic          o_owner;
  logic          o_locked;

  modport slave (
    input  i_r0_req, i_r0_we, i_r0_lock, i_r0_addr, i_r0_wdata,
    input  i_r1_req, i_r1_we, i_r1_lock, i_r1_addr, i_r1_wdata,
    input  i_mem_rdata,
    output o_r0_gnt, o_r0_rvalid, o_r0_rdata,
    output o_r1_gnt, o_r1_rvalid, o_r1_rdata,
    output o_mem_we, o_mem_re, o_mem_addr, o_mem_wdata,
    output o_owner, o_locked
  );

  modport master (
    output i_r0_req, i_r0_we, i_r0_lock, i_r0_addr, i_r0_wdata,
    output i_r1_req, i_r1_we, i_r1_lock, i_r1_addr, i_r1_wdata,
    output i_mem_rdata,
    input  o_r0_gnt, o_r0_rvalid, o_r0_rdata,
    input  o_r1_gnt, o_r1_rvalid, o_r1_rdata,
    input  o_mem_we, o_mem_re, o_mem_addr, o_mem_wdata,
    input  o_owner, o_locked
  );
endinterface

// File: rtl/ice51_mem_arb.sv
// Two-requester arbiter for one synchronous-read 512x8 memory: one access per
// cycle, round-robin or fixed priority, lockable for multi-cycle sequences.
module ice51_mem_arb #(
  parameter int AW        = 9,
  parameter int DW        = 8,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  ice51_mem_arb_if.slave bus
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  lock_state_e   state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_tag_q, rd_tag_d;

  logic          gnt0, gnt1;
  logic          accept, gnt_idx, acc_we, acc_lock, owner_lock;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == LOCKED) begin
      if (owner_q) gnt1 = bus.i_r1_req;
      else         gnt0 = bus.i_r0_req;
    end else if (bus.i_r0_req && bus.i_r1_req) begin
      // last_q == 1 means requester 1 was served last, so requester 0 is next.
      if (FIXED_PRI || last_q) gnt0 = 1'b1;
      else                     gnt1 = 1'b1;
    end else begin
      gnt0 = bus.i_r0_req;
      gnt1 = bus.i_r1_req;
    end
  end

  assign accept     = gnt0 | gnt1;
  assign gnt_idx    = gnt1;
  assign acc_we     = gnt_idx ? bus.i_r1_we   : bus.i_r0_we;
  assign acc_lock   = gnt_idx ? bus.i_r1_lock : bus.i_r0_lock;
  assign owner_lock = owner_q ? bus.i_r1_lock : bus.i_r0_lock;

  // Idle cycles present requester 0's fields with both enables low.
  assign mem_addr  = gnt1 ? bus.i_r1_addr  : bus.i_r0_addr;
  assign mem_wdata = gnt1 ? bus.i_r1_wdata : bus.i_r0_wdata;

  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_mem_we    = accept &  acc_we;
  assign bus.o_mem_re    = accept & ~acc_we;

  assign bus.o_r0_gnt = gnt0;
  assign bus.o_r1_gnt = gnt1;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    rd_tag_d  = rd_tag_q;
    rd_pend_d = 1'b0;

    if (accept) begin
      last_d = gnt_idx;
      if (!acc_we) begin
        rd_pend_d = 1'b1;
        rd_tag_d  = gnt_idx;
      end
    end

    case (state_q)
      UNLOCKED: begin
        if (accept && acc_lock) begin
          state_d = LOCKED;
          owner_d = gnt_idx;
        end
      end
      LOCKED: begin
        // The owner's final access (lock low) is still granted above.
        if (!owner_lock) state_d = UNLOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= UNLOCKED;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  assign bus.o_r0_rvalid = rd_pend_q & ~rd_tag_q;
  assign bus.o_r1_rvalid = rd_pend_q &  rd_tag_q;
  assign bus.o_r0_rdata  = bus.i_mem_rdata;
  assign bus.o_r1_rdata  = bus.i_mem_rdata;
  assign bus.o_locked    = (state_q == LOCKED);
  assign bus.o_owner     = owner_q;

endmodule

// File: tb/tb_ice51_mem_arb.sv
// Self-checking bench for ice51_mem_arb: a round-robin instance with a read-return
// scoreboard, and a fixed-priority instance for priority checks.
`timescale 1ns/1ps
module tb_ice51_mem_arb;
  localparam int AW = 9;
  localparam int DW = 8;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  ice51_mem_arb_if #(.AW(AW), .DW(DW)) rr_if ();
  ice51_mem_arb_if #(.AW(AW), .DW(DW)) fp_if ();

  ice51_mem_arb #(.AW(AW), .DW(DW), .FIXED_PRI(1'b0)) u_rr (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (rr_if.slave)
  );

  ice51_mem_arb #(.AW(AW), .DW(DW), .FIXED_PRI(1'b1)) u_fp (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (fp_if.slave)
  );

  logic [DW-1:0] mem_rr  [512];
  logic [DW-1:0] mem_fp  [512];
  logic [DW-1:0] ref_mem [512];

  function automatic logic [DW-1:0] pat(input int a);
    return 8'((a * 37 + 11) & 255);
  endfunction

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem_rr[i]  = pat(i);
      mem_fp[i]  = pat(i);
      ref_mem[i] = pat(i);
    end
  end

  // Synchronous-read memory models behind each arbiter.
  always @(posedge clk) begin
    if (rr_if.o_mem_we) mem_rr[rr_if.o_mem_addr] <= rr_if.o_mem_wdata;
    if (rr_if.o_mem_re) rr_if.i_mem_rdata <= mem_rr[rr_if.o_mem_addr];
    if (fp_if.o_mem_we) mem_fp[fp_if.o_mem_addr] <= fp_if.o_mem_wdata;
    if (fp_if.o_mem_re) fp_if.i_mem_rdata <= mem_fp[fp_if.o_mem_addr];
  end

  // Scoreboard: tasks push at the accepting cycle, the monitor pops after the edge.
  exp_t exp_q[$];
  exp_t mon_e;
  logic tb_last;

  always @(posedge clk) begin
    #1;
    n_checks++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (rr_if.o_r0_rvalid !== !mon_e.id || rr_if.o_r1_rvalid !== mon_e.id ||
          (mon_e.id ? rr_if.o_r1_rdata : rr_if.o_r0_rdata) !== mon_e.data)
        begin
        n_fail++;
        $display("FAIL rvalid_return t=%0t: got rv0=%b rv1=%b data=%h, expected rv0=%b rv1=%b data=%h",
                 $time, rr_if.o_r0_rvalid, rr_if.o_r1_rvalid,
                 (mon_e.id ? rr_if.o_r1_rdata : rr_if.o_r0_rdata),
                 !mon_e.id, mon_e.id, mon_e.data);
      end
    end else if (rr_if.o_r0_rvalid !== 1'b0 || rr_if.o_r1_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_rvalid t=%0t: got rv0=%b rv1=%b, expected 0 0",
               $time, rr_if.o_r0_rvalid, rr_if.o_r1_rvalid);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_r0(input logic req, input logic we, input logic lock,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    rr_if.i_r0_req = req; rr_if.i_r0_we = we; rr_if.i_r0_lock = lock;
    rr_if.i_r0_addr = addr; rr_if.i_r0_wdata = wdata;
  endtask

  task automatic set_r1(input logic req, input logic we, input logic lock,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    rr_if.i_r1_req = req; rr_if.i_r1_we = we; rr_if.i_r1_lock = lock;
    rr_if.i_r1_addr = addr; rr_if.i_r1_wdata = wdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_r0(0, 0, 0, '0, '0);
    set_r1(0, 0, 0, '0, '0);
    fp_if.i_r0_req = 0; fp_if.i_r0_we = 0; fp_if.i_r0_lock = 0;
    fp_if.i_r0_addr = '0; fp_if.i_r0_wdata = '0;
    fp_if.i_r1_req = 0; fp_if.i_r1_we = 0; fp_if.i_r1_lock = 0;
    fp_if.i_r1_addr = '0; fp_if.i_r1_wdata = '0;
    tb_last = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({rr_if.o_r0_rvalid, rr_if.o_r1_rvalid, rr_if.o_locked, rr_if.o_owner,
         rr_if.o_mem_re, rr_if.o_mem_we} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rv0 rv1 locked owner re we=%b, expected 000000",
               {rr_if.o_r0_rvalid, rr_if.o_r1_rvalid, rr_if.o_locked, rr_if.o_owner,
                rr_if.o_mem_re, rr_if.o_mem_we});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    set_r0(1, 0, 0, 9'h005, '0);
    #1;
    n_checks++;
    if ({rr_if.o_r0_gnt, rr_if.o_r1_gnt, rr_if.o_mem_re, rr_if.o_mem_we} !== 4'b1010 ||
        rr_if.o_mem_addr !== 9'h005) begin
      n_fail++;
      $display("FAIL single_read_grant: got gnt0 gnt1 re we=%b addr=%h, expected 1010 addr=005",
               {rr_if.o_r0_gnt, rr_if.o_r1_gnt, rr_if.o_mem_re, rr_if.o_mem_we}, rr_if.o_mem_addr);
    end
    exp_q.push_back('{id: 1'b0, data: ref_mem[9'h005]});
    tb_last = 1'b0;
    @(negedge clk);
    set_r0(0, 0, 0, '0, '0);
    #1;
    n_checks++;
    if ({rr_if.o_r0_gnt, rr_if.o_mem_re, rr_if.o_mem_we} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_no_enable: got gnt0 re we=%b, expected 000",
               {rr_if.o_r0_gnt, rr_if.o_mem_re, rr_if.o_mem_we});
    end
  endtask

  task automatic test_round_robin();
    logic          w;
    logic [AW-1:0] a;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_r0(1, 0, 0, 9'h010, '0);
      set_r1(1, 0, 0, 9'h1F0, '0);
      #1;
      w = ~tb_last;
      a = w ? 9'h1F0 : 9'h010;
      n_checks++;
      if (rr_if.o_r0_gnt !== ~w || rr_if.o_r1_gnt !== w || rr_if.o_mem_addr !== a) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got gnt0=%b gnt1=%b addr=%h, expected gnt0=%b gnt1=%b addr=%h",
                 i, rr_if.o_r0_gnt, rr_if.o_r1_gnt, rr_if.o_mem_addr, ~w, w, a);
      end
      exp_q.push_back('{id: w, data: ref_mem[a]});
      tb_last = w;
    end
    @(negedge clk);
    set_r0(0, 0, 0, '0, '0);
    set_r1(0, 0, 0, '0, '0);
  endtask

  task automatic test_fixed_pri();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      fp_if.i_r0_req = 1; fp_if.i_r0_we = 0; fp_if.i_r0_addr = 9'h010;
      fp_if.i_r1_req = 1; fp_if.i_r1_we = 0; fp_if.i_r1_addr = 9'h1F0;
      #1;
      n_checks++;
      if ({fp_if.o_r0_gnt, fp_if.o_r1_gnt} !== 2'b10) begin
        n_fail++;
        $display("FAIL fixed_pri_grant[%0d]: got gnt0 gnt1=%b, expected 10",
                 i, {fp_if.o_r0_gnt, fp_if.o_r1_gnt});
      end
    end
    @(negedge clk);
    fp_if.i_r0_req = 0;
    #1;
    n_checks++;
    if ({fp_if.o_r0_gnt, fp_if.o_r1_gnt} !== 2'b01 || fp_if.o_mem_addr !== 9'h1F0) begin
      n_fail++;
      $display("FAIL fixed_pri_r1_alone: got gnt0 gnt1=%b addr=%h, expected 01 addr=1f0",
               {fp_if.o_r0_gnt, fp_if.o_r1_gnt}, fp_if.o_mem_addr);
    end
    @(negedge clk);
    fp_if.i_r1_req = 0;
    #1;
    n_checks++;
    if ({fp_if.o_r0_rvalid, fp_if.o_r1_rvalid} !== 2'b01 || fp_if.o_r1_rdata !== pat(9'h1F0)) begin
      n_fail++;
      $display("FAIL fixed_pri_r1_data: got rv0 rv1=%b data=%h, expected 01 data=%h",
               {fp_if.o_r0_rvalid, fp_if.o_r1_rvalid}, fp_if.o_r1_rdata, pat(9'h1F0));
    end
  endtask

  task automatic test_lock();
    // r1 write 0xA5 to 0x100 taking the lock while r0 requests a read.
    @(negedge clk);
    set_r0(1, 0, 0, 9'h020, '0);
    set_r1(1, 1, 1, 9'h100, 8'hA5);
    #1;
    n_checks++;
    if ({rr_if.o_r0_gnt, rr_if.o_r1_gnt, rr_if.o_mem_we, rr_if.o_mem_re} !== 4'b0110 ||
        rr_if.o_mem_addr !== 9'h100 || rr_if.o_mem_wdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL lock_write: got gnt0 gnt1 we re=%b addr=%h wdata=%h, expected 0110 100 a5",
               {rr_if.o_r0_gnt, rr_if.o_r1_gnt, rr_if.o_mem_we, rr_if.o_mem_re},
               rr_if.o_mem_addr, rr_if.o_mem_wdata);
    end
    ref_mem[9'h100] = 8'hA5;
    tb_last = 1'b1;
    // Owner holds the lock but idles: port locked, r0 stalled.
    @(negedge clk);
    set_r1(0, 0, 1, 9'h100, '0);
    #1;
    n_checks++;
    if ({rr_if.o_locked, rr_if.o_owner, rr_if.o_r0_gnt, rr_if.o_r1_gnt,
         rr_if.o_mem_we, rr_if.o_mem_re} !== 6'b110000) begin
      n_fail++;
      $display("FAIL lock_idle_stall: got locked owner gnt0 gnt1 we re=%b, expected 110000",
               {rr_if.o_locked, rr_if.o_owner, rr_if.o_r0_gnt, rr_if.o_r1_gnt,
                rr_if.o_mem_we, rr_if.o_mem_re});
    end
    // Locked read, then the releasing read with lock low.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_r1(1, 0, (i == 0), 9'h100, '0);
      #1;
      n_checks++;
      if ({rr_if.o_r0_gnt, rr_if.o_r1_gnt, rr_if.o_locked} !== 3'b011) begin
        n_fail++;
        $display("FAIL lock_read[%0d]: got gnt0 gnt1 locked=%b, expected 011",
                 i, {rr_if.o_r0_gnt, rr_if.o_r1_gnt, rr_if.o_locked});
      end
      exp_q.push_back('{id: 1'b1, data: ref_mem[9'h100]});
    end
    // Lock released at the previous edge: r0 finally granted.
    @(negedge clk);
    set_r1(0, 0, 0, '0, '0);
    #1;
    n_checks++;
    if ({rr_if.o_locked, rr_if.o_r0_gnt, rr_if.o_r1_gnt} !== 3'b010 ||
        rr_if.o_mem_addr !== 9'h020) begin
      n_fail++;
      $display("FAIL unlock_r0_grant: got locked gnt0 gnt1=%b addr=%h, expected 010 addr=020",
               {rr_if.o_locked, rr_if.o_r0_gnt, rr_if.o_r1_gnt}, rr_if.o_mem_addr);
    end
    exp_q.push_back('{id: 1'b0, data: ref_mem[9'h020]});
    tb_last = 1'b0;
    @(negedge clk);
    set_r0(0, 0, 0, '0, '0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_r0(1, 0, 1, 9'h033, '0);
    #1;
    n_checks++;
    if (rr_if.o_r0_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_read1_grant: got gnt0=%b, expected 1", rr_if.o_r0_gnt);
    end
    exp_q.push_back('{id: 1'b0, data: ref_mem[9'h033]});
    @(negedge clk);
    set_r0(1, 0, 1, 9'h044, '0);
    #1;
    n_checks++;
    if ({rr_if.o_r0_gnt, rr_if.o_locked, rr_if.o_owner} !== 3'b110) begin
      n_fail++;
      $display("FAIL mid_read2_locked: got gnt0 locked owner=%b, expected 110",
               {rr_if.o_r0_gnt, rr_if.o_locked, rr_if.o_owner});
    end
    // Second read's rvalid appears; reset arrives within that cycle and kills it.
    @(posedge clk);
    #0.2;
    n_checks++;
    if (rr_if.o_r0_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rvalid_before_rst: got rv0=%b, expected 1", rr_if.o_r0_rvalid);
    end
    #0.3;
    rst = 1'b1;
    set_r0(0, 0, 0, '0, '0);
    tb_last = 1'b1;
    #0.2;
    n_checks++;
    if ({rr_if.o_r0_rvalid, rr_if.o_r1_rvalid, rr_if.o_locked} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset_drop: got rv0 rv1 locked=%b, expected 000",
               {rr_if.o_r0_rvalid, rr_if.o_r1_rvalid, rr_if.o_locked});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_r0(1, 0, 0, 9'h1FF, '0);
    #1;
    n_checks++;
    if ({rr_if.o_r0_gnt, rr_if.o_mem_re} !== 2'b11 || rr_if.o_mem_addr !== 9'h1FF) begin
      n_fail++;
      $display("FAIL post_reset_grant: got gnt0 re=%b addr=%h, expected 11 addr=1ff",
               {rr_if.o_r0_gnt, rr_if.o_mem_re}, rr_if.o_mem_addr);
    end
    exp_q.push_back('{id: 1'b0, data: ref_mem[9'h1FF]});
    tb_last = 1'b0;
    @(negedge clk);
    set_r0(0, 0, 0, '0, '0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_pri();
    test_lock();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
